apb3_fabric_master: RTL and testbench

//  Fabric-side APB3 initiator: turns single-word requests from fabric logic (command sequencer,

---
 rtl/apb3_fabric_master_pkg.sv | 31 +++
 rtl/apb3_fabric_master.sv | 149 ++++++++++++++
 tb/tb_apb3_fabric_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_fabric_master_pkg.sv
// Shared APB3 fabric-master types: FSM state encoding, default bus widths and
// request/response records used by fabric-side requesters.
package apb3_fabric_master_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_req_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

   // Width of a counter that must hold 0..limit; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/apb3_fabric_master.sv
// Fabric-side APB3 initiator: one request in, one APB3 transfer out, one response pulse back,
// with every ACCESS phase bounded by a PREADY timeout.
module apb3_fabric_master
   import apb3_fabric_master_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic              PCLK,
   input  logic              PRESET,
   // Request side: a request transfers on a rising edge where req_valid && req_ready.
   // req_ready is high only in IDLE; the requester holds req_valid and req_* until then.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output apb_state_e        dbg_state
);

   localparam int              CNT_W     = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

   apb_state_e        state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
   logic              req_ready_d;
   logic              psel_d, penable_d, pwrite_d;
   logic [ADDR_W-1:0] paddr_d;
   logic [DATA_W-1:0] pwdata_d;
   logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [DATA_W-1:0] rsp_rdata_d;

   // Saturating so a disabled timeout (TIMEOUT=0) with a long stall never wraps.
   assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
   assign dbg_state = state;

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      req_ready_d   = req_ready;
      psel_d        = PSEL;
      penable_d     = PENABLE;
      pwrite_d      = PWRITE;
      paddr_d       = PADDR;
      pwdata_d      = PWDATA;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;

      case (state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               pwrite_d    = req_write;
               paddr_d     = req_addr;
               pwdata_d    = req_wdata;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               req_ready_d = 1'b0;
               cnt_d       = '0;
               state_d     = ST_SETUP;
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end

         ST_ACCESS: begin
            // PREADY wins over a timeout landing on the same cycle.
            if (PREADY) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = PWRITE ? '0 : PRDATA;
               req_ready_d   = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = '0;
                  req_ready_d   = 1'b1;
                  state_d       = ST_IDLE;
               end
            end
         end

         default: begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         req_ready   <= 1'b1;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         req_ready   <= req_ready_d;
         PSEL        <= psel_d;
         PENABLE     <= penable_d;
         PWRITE      <= pwrite_d;
         PADDR       <= paddr_d;
         PWDATA      <= pwdata_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end

endmodule

// File: tb/tb_apb3_fabric_master.sv
// Self-checking bench for apb3_fabric_master: directed and random requests against a
// scripted APB slave, with responses scored from an expected queue.
module tb_apb3_fabric_master;
   import apb3_fabric_master_pkg::*;

   localparam int TO = 8;
   localparam int RW = 34;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic        err;
      logic [31:0] rdata;
   } plan_t;

   logic        PCLK, PRESET;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   apb_state_e  dbg_state;

   logic [RW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   int            exp_len_q[$];
   plan_t         plan_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   apb3_fabric_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .dbg_state(dbg_state)
   );

   // Clock / reset
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Driver: reference response follows directly from the slave script -- a transfer whose
   // slave stalls TO or more cycles is aborted, anything shorter completes normally.
   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic err, input logic [31:0] rdata, input bit keep);
      bit            abort;
      logic [RW-1:0] e;
      plan_t         p;
      int            t;
      abort = (waits >= TO);
      e = abort ? {32'h0, 1'b1, 1'b1} : {(wr ? 32'h0 : rdata), err, 1'b0};
      p = '{wr, addr, wdata, waits, err, rdata};
      @(negedge PCLK);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      t = 0;
      while (!req_ready && t < 100) begin
         @(negedge PCLK);
         t++;
      end
      if (!req_ready) begin
         check("accept_bound", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + (abort ? 2 + TO : 3 + waits));
      exp_len_q.push_back(abort ? TO + 1 : waits + 2);
      plan_q.push_back(p);
      @(posedge PCLK);
      #1;
      if (!keep) begin
         req_valid = 1'b0;
         req_write = 1'($urandom_range(0, 1));
         req_addr  = $urandom;
         req_wdata = $urandom;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 300) begin
         @(negedge PCLK);
         t++;
      end
      repeat (2) @(negedge PCLK);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Scripted slave: stalls plan.waits cycles, then returns plan data. Outside the ready
   // cycle PRDATA/PSLVERR carry noise that must never reach the response.
   initial begin
      plan_t cur;
      bit    in_xfer, have_plan, rdy;
      int    wcnt;
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      in_xfer = 0; have_plan = 0; wcnt = 0;
      cur = '{1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
      forever begin
         @(negedge PCLK);
         if (PSEL && PENABLE) begin
            if (!in_xfer) begin
               in_xfer = 1;
               wcnt = 0;
               have_plan = (plan_q.size() > 0);
               if (have_plan) cur = plan_q.pop_front();
            end
            if (have_plan) begin
               check("paddr_stable", 64'(PADDR), 64'(cur.addr));
               check("pwrite_stable", 64'(PWRITE), 64'(cur.wr));
               check("pwdata_stable", 64'(PWDATA), 64'(cur.wdata));
            end
            rdy = have_plan && (wcnt == cur.waits);
            PREADY  = rdy;
            PRDATA  = rdy ? cur.rdata : $urandom;
            PSLVERR = rdy ? cur.err : 1'($urandom_range(0, 1));
            wcnt++;
         end else begin
            in_xfer = 0;
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic [RW-1:0] e;
      int            c, l, psel_cnt, pen_cnt;
      psel_cnt = 0; pen_cnt = 0;
      forever begin
         @(negedge PCLK);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               c = exp_cyc_q.pop_front();
               check("rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(e));
               check("rsp_cycle", 64'(cyc), 64'(c));
               check("ready_at_rsp", 64'(req_ready), 64'd1);
            end
         end
         if (PSEL) begin
            psel_cnt++;
            if (PENABLE) pen_cnt++;
         end else if (psel_cnt > 0) begin
            if (exp_len_q.size() > 0) begin
               l = exp_len_q.pop_front();
               check("psel_len", 64'(psel_cnt), 64'(l));
               check("penable_len", 64'(pen_cnt), 64'(l - 1));
            end
            psel_cnt = 0;
            pen_cnt = 0;
         end
      end
   end

   // Stimulus
   initial begin
      int t;
      int w;
      PRESET = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_psel", 64'(PSEL), 64'd0);
      check("rst_penable", 64'(PENABLE), 64'd0);
      check("rst_pwrite", 64'(PWRITE), 64'd0);
      check("rst_paddr", 64'(PADDR), 64'd0);
      check("rst_pwdata", 64'(PWDATA), 64'd0);
      check("rst_rsp", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      PRESET = 1'b0;

      // Zero-wait write, stalled read, slave error with a request queued behind it
      send(1'b1, 32'h4005_0000, 32'h0000_01F4, 0, 1'b0, 32'h1234_5678, 1'b0);
      send(1'b0, 32'h4005_0004, 32'hAAAA_5555, 4, 1'b0, 32'hDEAD_BEEF, 1'b0);
      send(1'b1, 32'h4005_0008, 32'h0000_0001, 2, 1'b1, 32'h0F0F_0F0F, 1'b1);
      send(1'b0, 32'h4005_000C, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
      // Timeout boundary: stuck slave aborts; ready on the last allowed cycle completes
      send(1'b0, 32'h4005_0010, 32'h0, TO, 1'b1, 32'h1111_1111, 1'b0);
      send(1'b0, 32'h4005_0014, 32'h0, TO - 1, 1'b0, 32'h2222_2222, 1'b0);
      send(1'b1, 32'h4005_0018, 32'h3333_3333, TO + 12, 1'b0, 32'h4444_4444, 1'b0);
      send(1'b1, 32'h4005_001C, 32'h5555_5555, TO - 1, 1'b1, 32'h6666_6666, 1'b0);
      // Ten back-to-back reads with req_valid held
      for (int i = 0; i < 10; i++)
         send(1'b0, 32'h4006_0000 + 32'(i * 4), $urandom, 0, 1'b0, $urandom, (i < 9));
      drain();

      // Reset in the middle of ACCESS: no response may come out of the killed transfer
      @(negedge PCLK);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4007_0000;
      t = 0;
      while (!req_ready && t < 50) begin @(negedge PCLK); t++; end
      @(posedge PCLK);
      #1 req_valid = 1'b0;
      t = 0;
      while (dbg_state != ST_ACCESS && t < 20) begin @(negedge PCLK); t++; end
      check("reach_access", 64'(dbg_state), 64'(ST_ACCESS));
      repeat (2) @(negedge PCLK);
      PRESET = 1'b1;
      @(posedge PCLK);
      #1;
      check("midrst_psel", 64'(PSEL), 64'd0);
      check("midrst_penable", 64'(PENABLE), 64'd0);
      check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (TO + 4) @(negedge PCLK);
      check("midrst_ready", 64'(req_ready), 64'd1);
      check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         w = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 5);
         send(1'($urandom_range(0, 1)), $urandom, $urandom, w, 1'($urandom_range(0, 3) == 0),
              $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge PCLK);
      end
      @(negedge PCLK);
      req_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
